// File: rtl/pwm_cmd_sequencer.sv
// Avalon-MM write master for the 3-phase centre-aligned PWM servo: configures it after reset,
// turns per-phase on-times into deadtime-adjusted compare pairs and runs enable/fault sequencing.
module pwm_cmd_sequencer #(
  parameter logic [15:0] PERIOD   = 16'd3000,
  parameter logic [15:0] DEADTIME = 16'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_duty0,
  input  logic [15:0] cmd_duty1,
  input  logic [15:0] cmd_duty2,
  input  logic        arm,
  input  logic        fault,
  input  logic        pwm_irq,
  output logic [3:0]  MM_addr,
  output logic        MM_write,
  output logic [31:0] MM_writedata,
  input  logic        MM_waitrequest,
  output logic        enabled,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        busy
);

  typedef enum logic [2:0] {StCfg, StIdle, StLoad, StWr, StCommit, StEna, StDis} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [2:0]  idx_nxt;
  logic [2:0]  cfg_sel;
  logic [15:0] duty_q [3];
  logic [15:0] lo_q   [3];
  logic [15:0] hi_q   [3];
  logic [15:0] lo_c   [3];
  logic [15:0] hi_c   [3];
  logic        arm_q;
  logic        arm_pend_q;
  logic        fault_done_q;
  logic        beat_done;
  logic        arm_rise;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] wr_data;

  assign beat_done = MM_write & ~MM_waitrequest;
  assign arm_rise  = arm & ~arm_q;
  assign idx_nxt   = idx_q + 3'd1;
  assign cmd_ready = (state_q == StIdle) && !fault && !arm_pend_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hi_c[i] = PERIOD - ((duty_q[i] > PERIOD) ? PERIOD : duty_q[i]);
      lo_c[i] = (hi_c[i] > DEADTIME) ? (hi_c[i] - DEADTIME) : 16'd0;
    end
  end

  // First CFG beat launches from idx_q, later ones from the index after the completing beat.
  always_comb begin
    cfg_sel  = MM_write ? idx_nxt : idx_q;
    cfg_addr = 4'hD;
    cfg_data = 16'd0;
    case (cfg_sel)
      3'd0:    begin cfg_addr = 4'h8; cfg_data = PERIOD; end
      3'd1:    begin cfg_addr = 4'hA; cfg_data = 16'd1;  end
      3'd2:    begin cfg_addr = 4'hB; cfg_data = 16'd0;  end
      3'd3:    begin cfg_addr = 4'hC; cfg_data = 16'd1;  end
      default: begin cfg_addr = 4'hD; cfg_data = 16'd0;  end
    endcase
  end

  always_comb begin
    wr_data = hi_q[2];
    case (idx_nxt)
      3'd1:    wr_data = hi_q[0];
      3'd2:    wr_data = lo_q[1];
      3'd3:    wr_data = hi_q[1];
      3'd4:    wr_data = lo_q[2];
      default: wr_data = hi_q[2];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StCfg;
      idx_q        <= 3'd0;
      for (int i = 0; i < 3; i++) begin
        duty_q[i] <= 16'd0;
        lo_q[i]   <= 16'd0;
        hi_q[i]   <= 16'd0;
      end
      arm_q        <= 1'b1;
      arm_pend_q   <= 1'b0;
      fault_done_q <= 1'b0;
      MM_write     <= 1'b0;
      MM_addr      <= 4'h0;
      MM_writedata <= 32'd0;
      enabled      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      arm_q <= arm;
      if (fault) arm_pend_q <= 1'b0;
      else if (arm_rise) arm_pend_q <= 1'b1;
      if (!fault) fault_done_q <= 1'b0;
      if (pwm_irq && (state_q inside {StLoad, StWr, StCommit})) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;

      case (state_q)
        StCfg: begin
          if (!MM_write || beat_done) begin
            if (MM_write && idx_q == 3'd4) begin
              MM_write <= 1'b0;
              idx_q    <= 3'd0;
              state_q  <= StIdle;
            end else begin
              MM_write     <= 1'b1;
              MM_addr      <= cfg_addr;
              MM_writedata <= {16'd0, cfg_data};
              if (MM_write) idx_q <= idx_nxt;
            end
          end
        end
        StIdle: begin
          if (fault && !fault_done_q) begin
            MM_write <= 1'b1; MM_addr <= 4'h9; MM_writedata <= 32'd0; state_q <= StDis;
          end else if (arm_pend_q) begin
            MM_write <= 1'b1; MM_addr <= 4'h9; MM_writedata <= 32'd1; state_q <= StEna;
          end else if (cmd_valid && cmd_ready) begin
            duty_q[0] <= cmd_duty0;
            duty_q[1] <= cmd_duty1;
            duty_q[2] <= cmd_duty2;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          lo_q     <= lo_c;
          hi_q     <= hi_c;
          idx_q    <= 3'd0;
          MM_write <= 1'b1;
          if (fault) begin
            MM_addr <= 4'h9; MM_writedata <= 32'd0; state_q <= StDis;
          end else begin
            MM_addr <= 4'h0; MM_writedata <= {16'd0, lo_c[0]}; state_q <= StWr;
          end
        end
        StWr: begin
          if (beat_done) begin
            if (fault) begin
              MM_addr <= 4'h9; MM_writedata <= 32'd0; state_q <= StDis;
            end else if (idx_q == 3'd5) begin
              MM_addr <= 4'hF; MM_writedata <= 32'd1; state_q <= StCommit;
            end else begin
              idx_q        <= idx_nxt;
              MM_addr      <= {1'b0, idx_nxt};
              MM_writedata <= {16'd0, wr_data};
            end
          end
        end
        StCommit: begin
          if (beat_done) begin
            if (fault) begin
              MM_addr <= 4'h9; MM_writedata <= 32'd0; state_q <= StDis;
            end else begin
              MM_write <= 1'b0; state_q <= StIdle;
            end
          end
        end
        StEna: begin
          if (beat_done) begin
            enabled    <= 1'b1;
            arm_pend_q <= 1'b0;
            if (fault) begin
              MM_addr <= 4'h9; MM_writedata <= 32'd0; state_q <= StDis;
            end else begin
              MM_write <= 1'b0; state_q <= StIdle;
            end
          end
        end
        StDis: begin
          if (beat_done) begin
            enabled      <= 1'b0;
            fault_done_q <= fault;
            MM_write     <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StCfg;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Scoreboard bench for pwm_cmd_sequencer: expected servo writes are queued with their due cycle
// and checked by a monitor as each beat completes; scenario tasks check control outputs inline.
module tb_pwm_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_duty0 = 16'd0;
  logic [15:0] cmd_duty1 = 16'd0;
  logic [15:0] cmd_duty2 = 16'd0;
  logic        arm = 1'b0;
  logic        fault = 1'b0;
  logic        pwm_irq = 1'b0;
  logic [3:0]  MM_addr;
  logic        MM_write;
  logic [31:0] MM_writedata;
  logic        MM_waitrequest = 1'b0;
  logic        enabled;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic        busy;

  pwm_cmd_sequencer #(.PERIOD(16'd3000), .DEADTIME(16'd16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty0(cmd_duty0), .cmd_duty1(cmd_duty1), .cmd_duty2(cmd_duty2),
    .arm(arm), .fault(fault), .pwm_irq(pwm_irq),
    .MM_addr(MM_addr), .MM_write(MM_write), .MM_writedata(MM_writedata),
    .MM_waitrequest(MM_waitrequest), .enabled(enabled), .overrun(overrun),
    .clr_overrun(clr_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;   // -1: completion cycle not checked
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  // Reference model of the compare computation, PERIOD=3000, DEADTIME=16.
  function automatic logic [15:0] m_hi(input logic [15:0] t);
    if (t >= 16'd3000) return 16'd0;
    return 16'd3000 - t;
  endfunction

  function automatic logic [15:0] m_lo(input logic [15:0] t);
    logic [15:0] h;
    h = m_hi(t);
    if (h <= 16'd16) return 16'd0;
    return h - 16'd16;
  endfunction

  always @(negedge clk) begin
    if (reset_n && MM_write && !MM_waitrequest) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_beat: got addr=%h data=%0d at cyc=%0d, required no beat",
                 MM_addr, MM_writedata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (MM_addr !== mon_e.addr || MM_writedata !== mon_e.data ||
            (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          failures = failures + 1;
          $display("FAIL beat: got addr=%h data=%0d cyc=%0d, required addr=%h data=%0d cyc=%0d",
                   MM_addr, MM_writedata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic push_beat(input logic [3:0] a, input logic [31:0] d, input int c);
    beat_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Queue the first nbeats compare writes (plus the commit when all six) for a command at n.
  task automatic push_cmd(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                          input int n, input int hold, input int nbeats);
    logic [15:0] t [3];
    logic [15:0] d;
    t[0] = t0; t[1] = t1; t[2] = t2;
    for (int k = 0; k < nbeats; k++) begin
      d = (k % 2 == 1) ? m_hi(t[k / 2]) : m_lo(t[k / 2]);
      push_beat(4'(k), {16'd0, d}, n + 2 + k + ((k >= 2) ? hold : 0));
    end
    if (nbeats == 6) push_beat(4'hF, 32'd1, n + 8 + hold);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2,
                          output int n);
    n = -1;
    @(posedge clk);
    #1;
    cmd_duty0 = t0; cmd_duty1 = t1; cmd_duty2 = t2;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        n = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checks = checks + 1;
    if (n < 0) begin
      failures = failures + 1;
      $display("FAIL cmd_accept: got cmd_ready never high, required acceptance within 50 cycles");
    end
  endtask

  // Release reset and expect the five configuration writes on consecutive cycles.
  task automatic run_cfg();
    int r;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    r = cyc;
    push_beat(4'h8, 32'd3000, r + 1);
    push_beat(4'hA, 32'd1, r + 2);
    push_beat(4'hB, 32'd0, r + 3);
    push_beat(4'hC, 32'd1, r + 4);
    push_beat(4'hD, 32'd0, r + 5);
    wait_cyc(r + 5);
    @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL cfg_busy: got busy=%b cmd_ready=%b, required busy=1 cmd_ready=0",
               busy, cmd_ready);
    end
    @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL cfg_done: got busy=%b cmd_ready=%b pending=%0d, required 0 1 0",
               busy, cmd_ready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if ({MM_write, MM_addr, MM_writedata, cmd_ready, enabled, overrun, busy} !==
        {1'b0, 4'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures = failures + 1;
      $display("FAIL reset_vals: got wr=%b addr=%h data=%0d rdy=%b en=%b ovr=%b busy=%b, required 0 0 0 0 0 0 1",
               MM_write, MM_addr, MM_writedata, cmd_ready, enabled, overrun, busy);
    end
    run_cfg();
  endtask

  task automatic test_command();
    int n;
    send_cmd(16'd1000, 16'd0, 16'd5000, n);
    push_cmd(16'd1000, 16'd0, 16'd5000, n, 0, 6);
    wait_cyc(n + 8);
    @(negedge clk);
    checks = checks + 1;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL cmd_commit_busy: got cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
    end
    @(negedge clk);
    checks = checks + 1;
    if (cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL cmd_ready_n9: got cmd_ready=%b pending=%0d, required 1 0",
               cmd_ready, exp_q.size());
    end
  endtask

  task automatic test_deadtime_wait();
    int n;
    send_cmd(16'd10, 16'd10, 16'd10, n);
    push_cmd(16'd10, 16'd10, 16'd10, n, 0, 6);
    wait_drain();
    send_cmd(16'd2995, 16'd0, 16'd3000, n);
    push_cmd(16'd2995, 16'd0, 16'd3000, n, 3, 6);
    wait_cyc(n + 4);
    MM_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (MM_write !== 1'b1 || MM_addr !== 4'h2 || MM_writedata !== 32'd2984) begin
        failures = failures + 1;
        $display("FAIL wait_hold%0d: got wr=%b addr=%h data=%0d, required 1 2 2984",
                 k, MM_write, MM_addr, MM_writedata);
      end
    end
    @(posedge clk);
    #1;
    MM_waitrequest = 1'b0;
    wait_cyc(n + 12);
    @(negedge clk);
    checks = checks + 1;
    if (cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL wait_done: got cmd_ready=%b pending=%0d, required 1 0",
               cmd_ready, exp_q.size());
    end
  endtask

  task automatic test_arm_fault();
    int n;
    @(posedge clk);
    #1;
    arm = 1'b1;
    push_beat(4'h9, 32'd1, -1);
    for (int i = 0; i < 20 && enabled !== 1'b1; i++) @(negedge clk);
    checks = checks + 1;
    if (enabled !== 1'b1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL arm_enable: got enabled=%b pending=%0d, required 1 0", enabled, exp_q.size());
    end
    arm = 1'b0;
    send_cmd(16'd100, 16'd200, 16'd300, n);
    push_cmd(16'd100, 16'd200, 16'd300, n, 0, 4);
    push_beat(4'h9, 32'd0, n + 6);
    wait_cyc(n + 5);
    fault = 1'b1;
    wait_cyc(n + 7);
    @(negedge clk);
    checks = checks + 1;
    if (enabled !== 1'b0 || exp_q.size() != 0 || cmd_ready !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL fault_dis: got enabled=%b pending=%0d cmd_ready=%b, required 0 0 0",
               enabled, exp_q.size(), cmd_ready);
    end
    @(posedge clk);
    #1;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    repeat (8) @(negedge clk);
    checks = checks + 1;
    if (enabled !== 1'b0 || cmd_ready !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL fault_arm_ignored: got enabled=%b cmd_ready=%b, required 0 0",
               enabled, cmd_ready);
    end
    @(posedge clk);
    #1;
    fault = 1'b0;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL fault_release: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    // A fresh fault while already disabled still writes En=0.
    @(posedge clk);
    #1;
    fault = 1'b1;
    push_beat(4'h9, 32'd0, -1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    fault = 1'b0;
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0 || enabled !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL fault_while_dis: got pending=%0d enabled=%b, required 0 0",
               exp_q.size(), enabled);
    end
  endtask

  task automatic test_overrun();
    int n;
    send_cmd(16'd500, 16'd1500, 16'd2500, n);
    push_cmd(16'd500, 16'd1500, 16'd2500, n, 0, 6);
    wait_cyc(n + 3);
    pwm_irq = 1'b1;
    @(posedge clk);
    #1;
    pwm_irq = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (overrun !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overrun_set: got overrun=%b, required 1", overrun);
    end
    wait_cyc(n + 9);
    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0 || cmd_ready !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overrun_seq_done: got pending=%0d cmd_ready=%b, required 0 1",
               exp_q.size(), cmd_ready);
    end
    @(posedge clk);
    #1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (overrun !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL overrun_clr: got overrun=%b, required 0", overrun);
    end
    @(posedge clk);
    #1;
    pwm_irq = 1'b1;
    @(posedge clk);
    #1;
    pwm_irq = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (overrun !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL overrun_idle_irq: got overrun=%b, required 0", overrun);
    end
    send_cmd(16'd2000, 16'd1000, 16'd0, n);
    push_cmd(16'd2000, 16'd1000, 16'd0, n, 0, 6);
    wait_cyc(n + 4);
    pwm_irq = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    pwm_irq = 1'b0;
    clr_overrun = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (overrun !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overrun_set_wins: got overrun=%b, required 1", overrun);
    end
    wait_drain();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL overrun_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_midreset();
    int n;
    send_cmd(16'd1200, 16'd2400, 16'd600, n);
    push_cmd(16'd1200, 16'd2400, 16'd600, n, 0, 4);
    wait_cyc(n + 6);
    MM_waitrequest = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (MM_write !== 1'b1 || MM_addr !== 4'h4 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL midreset_pre: got wr=%b addr=%h pending=%0d, required 1 4 0",
               MM_write, MM_addr, exp_q.size());
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks = checks + 1;
    if (MM_write !== 1'b0 || overrun !== 1'b0 || busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL midreset_async: got wr=%b overrun=%b busy=%b, required 0 0 1",
               MM_write, overrun, busy);
    end
    MM_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    run_cfg();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, required bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_command();
    test_deadtime_wait();
    test_arm_fault();
    test_overrun();
    test_midreset();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
